// File: rtl/jtag_master_if.sv
`default_nettype none
// ============================================================================
// Module   : jtag_master_if
// Purpose  : Command/response bus between a host and the jtag_master engine.
// Revision : 1.0
// ============================================================================
interface jtag_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/jtag_master.sv
`default_nettype none
// ============================================================================
// Module   : jtag_master
// Purpose  : JTAG initiator; walks the TAP from Run-Test/Idle through one scan,
//            a reset or idle clocks. JTAG_MASTER_TRST_EN adds trst_n_o.
// Revision : 1.0
// ============================================================================
module jtag_master #(
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    jtag_master_if.slave bus,
    output logic         tck_o,
    output logic         tms_o,
    output logic         tdi_o,
    input  logic         tdo_i
`ifdef JTAG_MASTER_TRST_EN
    ,
    output logic         trst_n_o
`endif
);

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [5:0]  len_q;
    logic [31:0] data_q;
    logic [5:0]  k_q;
    logic [7:0]  div_q;
    logic        tck_q, tms_q, tdi_q, ready_q, rsp_valid_q;
    logic [31:0] rsp_data_q;

    logic [5:0]  len_d;
    logic        xfer, tick, tck_fall;

    // TCKs spent walking from Run-Test/Idle to the shift state.
    function automatic logic [5:0] pre_len(input logic [1:0] op);
        case (op)
            OP_IR:   return 6'd4;
            OP_DR:   return 6'd3;
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [5:0] total_tcks(input logic [1:0] op, input logic [5:0] len);
        case (op)
            OP_RESET: return 6'd6;
            OP_IR:    return len + 6'd6;
            OP_DR:    return len + 6'd5;
            default:  return len;
        endcase
    endfunction

    function automatic logic is_shift(input logic [1:0] op, input logic [5:0] len,
                                      input logic [5:0] k);
        return (op == OP_IR || op == OP_DR) && (k > pre_len(op)) && (k <= pre_len(op) + len);
    endfunction

    function automatic logic [4:0] bit_idx(input logic [1:0] op, input logic [5:0] k);
        logic [5:0] t;
        t = k - pre_len(op) - 6'd1;
        return t[4:0];
    endfunction

    function automatic logic tms_at(input logic [1:0] op, input logic [5:0] len,
                                    input logic [5:0] k);
        logic [5:0] last;
        last = pre_len(op) + len;
        case (op)
            OP_RESET: return k != 6'd6;
            OP_IR, OP_DR: begin
                if (k <= pre_len(op))
                    return (k == 6'd1) || (op == OP_IR && k == 6'd2);
                else
                    return (k == last) || (k == last + 6'd1);
            end
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic tdi_at(input logic [1:0] op, input logic [5:0] len,
                                    input logic [5:0] k, input logic [31:0] data);
        return is_shift(op, len, k) ? data[bit_idx(op, k)] : 1'b0;
    endfunction

    assign len_d    = (bus.cmd_len == 6'd0 || bus.cmd_len > 6'd32) ? 6'd32 : bus.cmd_len;
    assign xfer     = (state_q == S_IDLE) && bus.cmd_valid && ready_q;
    assign tick     = (div_q == DIV_LAST);
    assign tck_fall = (state_q == S_RUN) && tick && tck_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            len_q       <= 6'd0;
            data_q      <= 32'd0;
            k_q         <= 6'd0;
            div_q       <= 8'd0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b0;
            tdi_q       <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (xfer) begin
                        state_q    <= S_RUN;
                        ready_q    <= 1'b0;
                        op_q       <= bus.cmd_op;
                        len_q      <= len_d;
                        data_q     <= bus.cmd_data;
                        k_q        <= 6'd1;
                        div_q      <= 8'd0;
                        tck_q      <= 1'b0;
                        tms_q      <= tms_at(bus.cmd_op, len_d, 6'd1);
                        tdi_q      <= tdi_at(bus.cmd_op, len_d, 6'd1, bus.cmd_data);
                        rsp_data_q <= 32'd0;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        div_q <= 8'd0;
                        tck_q <= ~tck_q;
                        if (!tck_q) begin
                            // Rising edge: TDO has had half a TCK to settle.
                            if (is_shift(op_q, len_q, k_q))
                                rsp_data_q[bit_idx(op_q, k_q)] <= tdo_i;
                        end else if (k_q == total_tcks(op_q, len_q)) begin
                            state_q     <= S_DONE;
                            rsp_valid_q <= 1'b1;
                            tms_q       <= 1'b0;
                            tdi_q       <= 1'b0;
                        end else begin
                            k_q   <= k_q + 6'd1;
                            tms_q <= tms_at(op_q, len_q, k_q + 6'd1);
                            tdi_q <= tdi_at(op_q, len_q, k_q + 6'd1, data_q);
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef JTAG_MASTER_TRST_EN
    logic trst_q;

    // Held low from TCK 1 of a reset command until the fall of TCK 5.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            trst_q <= 1'b0;
        else if (xfer && bus.cmd_op == OP_RESET)
            trst_q <= 1'b0;
        else if (state_q != S_RUN)
            trst_q <= 1'b1;
        else if (tck_fall && op_q == OP_RESET && k_q == 6'd5)
            trst_q <= 1'b1;
    end

    assign trst_n_o = trst_q;
`endif

    assign tck_o         = tck_q;
    assign tms_o         = tms_q;
    assign tdi_o         = tdi_q;
    assign bus.cmd_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule
`default_nettype wire
